// File: rtl/icache_dm_if.sv
// Fetch-side and instruction-memory-side signals of the direct-mapped
// instruction cache. The slave modport is the cache itself; the master
// modport is the surrounding pipeline plus memory.
interface icache_dm_if;
    // fetch side
    logic [31:0] addr;
    logic        req;
    logic        inv;
    logic [31:0] cmd;
    logic        hit;
    logic        istall;
    // instruction memory side
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  addr, req, inv, mem_rdata, mem_valid,
        output cmd, hit, istall, mem_req, mem_addr
    );

    modport master (
        output addr, req, inv, mem_rdata, mem_valid,
        input  cmd, hit, istall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache. A hit returns the instruction in the same
// cycle; a miss stalls the pipeline while the whole line is refilled
// word-by-word (beats 0..WORDS-1 in order) over a valid/ready memory port.
// Optional build macro ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_dm #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    typedef enum logic [0:0] {IDLE, FILL} state_e;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];
    logic [TAG_W-1:0]  miss_tag_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [OFF_W-1:0]  beat_q;
    logic              pend_inv_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_addr_bits;
    logic              lookup_hit;
    logic              hit_c;
    logic              start_fill;
    logic              beat_done;
    logic              fill_done;

    assign req_off          = bus.addr[2 +: OFF_W];
    assign req_idx          = bus.addr[2 + OFF_W +: IDX_W];
    assign req_tag          = bus.addr[31 -: TAG_W];
    assign unused_addr_bits = ^bus.addr[1:0];
    assign beat_done        = (state_q == FILL) && bus.mem_valid;
    assign fill_done        = beat_done && (beat_q == LAST_BEAT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Lookup, stall, memory request and next-state decode
    always_comb begin
        state_d      = state_q;
        hit_c        = 1'b0;
        start_fill   = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;
        lookup_hit   = bus.req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        case (state_q)
            IDLE: begin
                hit_c = lookup_hit;
                if (bus.req && !lookup_hit) begin
                    start_fill = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
                if (fill_done) state_d = IDLE;
            end
        endcase
        bus.hit    = hit_c;
        bus.cmd    = hit_c ? data_q[req_idx][req_off] : '0;
        bus.istall = bus.req && !hit_c;
    end

    // Miss bookkeeping, beat counter and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            beat_q     <= '0;
            pend_inv_q <= 1'b0;
        end else begin
            if (start_fill) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
                beat_q     <= '0;
            end
            if (beat_done) beat_q <= beat_q + 1'b1;
            if (state_q == IDLE && bus.inv) valid_q <= '0;
            if (state_q == FILL && bus.inv && !fill_done) pend_inv_q <= 1'b1;
            // An invalidate seen during the fill, or on its last beat, also
            // kills the line that was just brought in.
            if (fill_done) begin
                pend_inv_q <= 1'b0;
                if (pend_inv_q || bus.inv) valid_q <= '0;
                else                       valid_q[miss_idx_q] <= 1'b1;
            end
        end
    end

    // Tag and data storage (not reset; guarded by the valid bits)
    always_ff @(posedge clk) begin
        if (!rst && beat_done) data_q[miss_idx_q][beat_q] <= bus.mem_rdata;
        if (!rst && fill_done) tag_q[miss_idx_q] <= miss_tag_q;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating performance counters, cleared by reset or invalidate
    always_ff @(posedge clk) begin
        if (rst || bus.inv) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_c && hit_cnt_q != '1)       hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (start_fill && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the PC and the slow instruction memory port. It replaces the combinational instruction memory and feeds the FETCH->DECODE pipeline register.
- On a hit it returns the instruction in the same cycle.
- On a miss it raises a stall, refills the whole line word-by-word over a valid/ready memory handshake, then releases the stall.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  fetch address from PC; bits [1:0] ignored
- req  in  1  fetch request valid this cycle
- inv  in  1  invalidate all lines (single-cycle pulse)
- cmd  out  32  instruction word; 0 (NOP) when not a hit
- hit  out  1  cmd is valid this cycle
- istall  out  1  pipeline must hold PC and FETCH->DECODE register
- mem_req  out  1  word read request to instruction memory
- mem_addr  out  32  word address of current refill beat, bits [1:0] = 0
- mem_rdata  in  32  returned word
- mem_valid  in  1  mem_rdata valid; completes the current beat

Behaviour:
- Address split:
  - offset = addr[2+log2(WORDS)-1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per line, one valid bit, a tag, and WORDS data words.
- Lookup is combinational: hit = req & valid[index] & (tag match) & (state==IDLE). cmd = data[index][offset] when hit, else 0.
- istall = req & ~hit, combinationally. When req=0, istall=0.
- FSM states: IDLE, FILL.
- IDLE:
  - On req & ~hit, latch miss_tag and miss_index, clear the beat counter, and go to FILL.
  - The cycle in which the miss is detected already shows istall=1.
- FILL:
  - mem_req=1.
  - mem_addr = {miss_tag, miss_index, beat, 2'b00}; held stable until mem_valid.
  - Each cycle with mem_valid: write mem_rdata to data[miss_index][beat], then beat++.
  - After the beat WORDS-1 is accepted: set valid[miss_index]=1, set tag[miss_index]=miss_tag, go to IDLE.
  - The first IDLE cycle re-looks up addr. With PC held this is a hit, so istall=0 that cycle. Miss-to-hit latency is at least WORDS+1 cycles.
- The refill always fetches beats 0..WORDS-1 in order; it does not fetch the critical word first.
- During FILL, istall stays 1 whenever req=1. Changes on addr are ignored. A redirect mid-fill does not abort the fill.
- The memory side accepts back-to-back mem_valid; one beat per cycle is the maximum. mem_valid while in IDLE is ignored.
- inv in IDLE: all valid bits are cleared on that edge. In the same cycle the lookup still uses the pre-clear valids.
- inv in FILL: latched as pending. At fill completion all valid bits are cleared, including the line just filled. pending clears.
- inv at the completion edge has the same effect as pending inv.
- Reset:
  - All valid bits = 0, state = IDLE, beat = 0, pending_inv = 0.
  - Outputs: mem_req = 0, mem_addr = 0, hit = 0, cmd = 0, istall = 0 while req = 0.
  - Tag and data arrays are not reset.
  - rst mid-FILL abandons the fill. The line stays invalid. mem_req drops the cycle after the reset edge.
- Beat counter is log2(WORDS) bits wide and wraps naturally; wrap only occurs at the completion edge.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, adds the following outputs:
  - hit_cnt out 32: counts cycles with req & hit.
  - miss_cnt out 32: counts IDLE->FILL transitions.
- Both counters are reset to 0 by rst, saturate at 32'hFFFFFFFF, and are cleared by inv.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Cold miss: after reset, req=1, addr=0x0000_0040.
  - Required: istall=1 and mem_req=1 with mem_addr 0x40, 0x44, 0x48, 0x4C in order.
  - Memory returns 0x20080001..0x20080004 with mem_valid on consecutive cycles.
  - Next cycle: hit=1, cmd=0x20080001, istall=0.
  - Then addr=0x4C: hit in the same cycle, cmd=0x20080004.
- Conflict eviction: fill 0x40, then req addr 0x140 (same index, different tag).
  - Required: miss and refill from 0x140.
  - Afterwards, addr 0x40 misses again.
- Slow memory: mem_valid asserted only every third cycle.
  - Required: mem_addr is held stable between beats, istall=1 throughout, beats are written correctly, and the total stall is 12+ cycles.
- Redirect mid-fill: addr changes to 0x200 during the fill of 0x40.
  - Required: the fill of 0x40 completes.
  - Then 0x200 misses and a new fill starts at 0x200.
- Invalidate: inv pulse in IDLE after 0x40 is cached.
  - Required: the next access to 0x40 misses.
  - Inv during a fill: the line just filled is invalid at completion, and a re-access misses.
- Reset mid-fill: rst at beat 2.
  - Required: mem_req=0 after the edge.
  - Re-access of the same address performs a full 4-beat fill starting at beat 0.
  - With ICACHE_PERF_EN defined: miss_cnt=1 after the re-fill.
